// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter that drains a show-ahead byte FIFO, one pop per frame.
// Bit timing comes from an internal clock-per-bit divisor.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      clk_cnt, clk_cnt_nxt;
  logic [2:0]            bit_cnt, bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic                  tx_nxt;
  logic                  done_nxt;
  logic                  bit_end;

  assign bit_end = (clk_cnt == CNT_MAX);
  assign tx_busy = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    tx_nxt      = tx;
    done_nxt    = 1'b0;
    fifo_pop    = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt      = 1'b1;
        clk_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        // The pop cycle is the last idle-high cycle; the start bit begins at this edge.
        if (!fifo_empty && rst) begin
          fifo_pop  = 1'b1;
          shift_nxt = fifo_rdata;
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          tx_nxt      = shift[0];
          state_nxt   = DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          if (bit_cnt == BIT_LAST) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            // Shift right so the next payload bit is always at index 1, then index 0.
            bit_cnt_nxt = bit_cnt + 1'b1;
            shift_nxt   = {1'b0, shift[DATA_WIDTH-1:1]};
            tx_nxt      = shift[1];
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          done_nxt    = 1'b1;
          state_nxt   = IDLE;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      default: begin
        tx_nxt    = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
      tx      <= tx_nxt;
      tx_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4: per-cycle logs of tx/pop/done/busy
// are compared against hand-computed frames and timings.
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int LOG_N = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] fifo_rdata;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  logic [7:0] drv_rdata = 8'h00;
  logic       drv_empty = 1'b1;
  logic       use_fifo  = 1'b0;

  // Small show-ahead FIFO model for the back-to-back case.
  logic [7:0] mem [0:3];
  int         wr_cnt = 0;
  int         rd_cnt = 0;

  logic txl   [0:LOG_N-1];
  logic popl  [0:LOG_N-1];
  logic donel [0:LOG_N-1];
  logic busyl [0:LOG_N-1];

  int n_tests = 0;
  int n_fail  = 0;

  assign fifo_rdata = use_fifo ? mem[rd_cnt[1:0]] : drv_rdata;
  assign fifo_empty = use_fifo ? (wr_cnt == rd_cnt) : drv_empty;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (use_fifo && fifo_pop) rd_cnt <= rd_cnt + 1;
  end

  fifo_uart_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty),
    .fifo_pop  (fifo_pop),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller is just past a falling edge; sample i=0 is taken in that same half-cycle.
  task automatic run_log(input int n, input bit auto_empty, input bit toggle);
    bit pend;
    pend = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (auto_empty && pend) drv_empty = 1'b1;
      if (toggle && i >= 6 && i < 36) begin
        drv_empty = i[0];
        drv_rdata = 8'(i * 37);
      end else if (toggle && i >= 36) begin
        drv_empty = 1'b1;
      end
      #1;
      txl[i]   = tx;
      popl[i]  = fifo_pop;
      donel[i] = tx_done;
      busyl[i] = tx_busy;
      pend     = pend | fifo_pop;
    end
  endtask

  function automatic int cnt(input int sel, input int lo, input int hi);
    int s;
    s = 0;
    for (int i = lo; i <= hi; i++) begin
      case (sel)
        0:       s += int'(txl[i]);
        1:       s += int'(popl[i]);
        2:       s += int'(donel[i]);
        default: s += int'(busyl[i]);
      endcase
    end
    return s;
  endfunction

  function automatic int find_fall(input int from, input int last);
    for (int i = (from < 1 ? 1 : from); i <= last; i++)
      if (txl[i-1] == 1'b1 && txl[i] == 1'b0) return i;
    return -1;
  endfunction

  // Frame starting at sample f: start, 8 data bits LSB first, stop, each CPB samples.
  task automatic check_frame(input string tag, input int f, input logic [7:0] b);
    logic [9:0] fr;
    logic [3:0] got;
    fr = {1'b1, b, 1'b0};
    check({tag, "_found"}, 32'(f >= 1 && f + 10*CPB <= LOG_N), 32'd1);
    if (f < 1 || f + 10*CPB > LOG_N) return;
    for (int j = 0; j < 10; j++) begin
      got = {txl[f+4*j], txl[f+4*j+1], txl[f+4*j+2], txl[f+4*j+3]};
      check($sformatf("%s_bit%0d", tag, j), 32'(got), 32'({4{fr[j]}}));
    end
  endtask

  initial begin
    int f1, f2, f3;

    // Reset held two cycles with data waiting.
    rst       = 1'b0;
    drv_empty = 1'b0;
    drv_rdata = 8'h77;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check($sformatf("rst_pop%0d", k),  32'(fifo_pop), 32'd0);
      check($sformatf("rst_tx%0d", k),   32'(tx),       32'd1);
      check($sformatf("rst_busy%0d", k), 32'(tx_busy),  32'd0);
      check($sformatf("rst_done%0d", k), 32'(tx_done),  32'd0);
    end

    // Single byte A5.
    @(negedge clk);
    rst       = 1'b1;
    drv_rdata = 8'hA5;
    drv_empty = 1'b0;
    run_log(46, 1'b1, 1'b0);
    check("a5_pop0",     32'(popl[0]),           32'd1);
    check("a5_npop",     32'(cnt(1, 0, 45)),     32'd1);
    check("a5_fall",     32'(find_fall(1, 45)),  32'd1);
    check_frame("a5", 1, 8'hA5);
    check("a5_busy",     32'(cnt(3, 1, 40)),     32'd40);
    check("a5_busy_end", 32'(busyl[41]),         32'd0);
    check("a5_done_at",  32'(donel[41]),         32'd1);
    check("a5_ndone",    32'(cnt(2, 0, 45)),     32'd1);

    // Back-to-back through the FIFO model.
    @(negedge clk);
    mem[0]   = 8'h00;
    mem[1]   = 8'hFF;
    mem[2]   = 8'h55;
    mem[3]   = 8'h00;
    wr_cnt   = 3;
    use_fifo = 1'b1;
    run_log(140, 1'b0, 1'b0);
    f1 = find_fall(1, 139);
    f2 = find_fall(f1 + 1, 139);
    f3 = find_fall(f2 + 1, 139);
    check("b2b_f1",    32'(f1),               32'd1);
    check("b2b_gap12", 32'(f2 - f1),          32'd41);
    check("b2b_gap23", 32'(f3 - f2),          32'd41);
    check_frame("b2b_00", f1, 8'h00);
    check_frame("b2b_ff", f2, 8'hFF);
    check_frame("b2b_55", f3, 8'h55);
    check("b2b_npop",  32'(cnt(1, 0, 139)),   32'd3);
    check("b2b_rdcnt", 32'(rd_cnt),           32'd3);
    check("b2b_empty", 32'(fifo_empty),       32'd1);
    check("b2b_ndone", 32'(cnt(2, 0, 139)),   32'd3);
    use_fifo = 1'b0;

    // Idle hold.
    @(negedge clk);
    drv_empty = 1'b1;
    run_log(100, 1'b0, 1'b0);
    check("idle_txhigh", 32'(cnt(0, 0, 99)), 32'd100);
    check("idle_npop",   32'(cnt(1, 0, 99)), 32'd0);
    check("idle_nbusy",  32'(cnt(3, 0, 99)), 32'd0);

    // Reset during DATA bit 3 of 3C.
    @(negedge clk);
    drv_rdata = 8'h3C;
    drv_empty = 1'b0;
    run_log(19, 1'b1, 1'b0);
    check("mid_bit3", 32'(txl[18]),   32'd1);
    check("mid_busy", 32'(busyl[18]), 32'd1);
    @(negedge clk);
    rst       = 1'b0;
    drv_empty = 1'b0;
    @(negedge clk); #1;
    check("mid_rst_tx",   32'(tx),       32'd1);
    check("mid_rst_busy", 32'(tx_busy),  32'd0);
    check("mid_rst_done", 32'(tx_done),  32'd0);
    check("mid_rst_pop",  32'(fifo_pop), 32'd0);
    drv_empty = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    run_log(60, 1'b0, 1'b0);
    check("mid_after_tx",   32'(cnt(0, 0, 59)), 32'd60);
    check("mid_after_done", 32'(cnt(2, 0, 59)), 32'd0);
    check("mid_after_pop",  32'(cnt(1, 0, 59)), 32'd0);

    // Empty/data toggling while the frame of 96 is in flight.
    @(negedge clk);
    drv_rdata = 8'h96;
    drv_empty = 1'b0;
    run_log(46, 1'b1, 1'b1);
    check("tog_pop0", 32'(popl[0]),          32'd1);
    check("tog_npop", 32'(cnt(1, 0, 45)),    32'd1);
    check("tog_fall", 32'(find_fall(1, 45)), 32'd1);
    check_frame("tog", 1, 8'h96);
    check("tog_done", 32'(donel[41]),        32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
